// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer and its select mux.
// Holds the FSM state encoding and the default word/select widths.
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = 3;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 bit-select mux: y = i[s].
// This is the same block that serves as the 8:1 data-select mux downstream.
module mux_nto1 #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic [WIDTH-1:0] i,
  input  logic [SEL_W-1:0] s,
  output logic             y
);

  assign y = i[s];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// The select index steps through the held word, one position per accepted output bit.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_START = (MSB_FIRST != 0) ? SEL_W'(WIDTH - 1) : '0;
  localparam logic [SEL_W-1:0] SEL_END   = (MSB_FIRST != 0) ? '0 : SEL_W'(WIDTH - 1);

  state_t           state_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [WIDTH-1:0] held_word_reg;

  logic shifting;
  logic xfer;
  logic accept;

  assign shifting  = (state_reg == ST_SHIFT);
  assign out_valid = shifting;
  assign busy      = shifting;
  assign out_last  = shifting && (sel_reg == SEL_END);
  assign sel       = sel_reg;

  // Accepting on the last-bit transfer lets the next word follow with no bubble.
  assign in_ready  = !rst && (!shifting || (out_last && out_ready));
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  mux_nto1 #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_bit_mux (
    .i (held_word_reg),
    .s (sel_reg),
    .y (out_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= SEL_START;
      held_word_reg <= '0;
    end else if (accept) begin
      held_word_reg <= in_data;
      sel_reg       <= SEL_START;
      state_reg     <= ST_SHIFT;
    end else if (xfer) begin
      if (out_last) begin
        state_reg <= ST_IDLE;
        sel_reg   <= SEL_START;
      end else if (MSB_FIRST != 0) begin
        sel_reg <= sel_reg - SEL_W'(1);
      end else begin
        sel_reg <= sel_reg + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first and an MSB-first instance share one stimulus stream.
// A bit-count model checks every cycle; captured streams are also checked against literal words.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic       in_ready_o  [2];
  logic       out_bit_o   [2];
  logic       out_valid_o [2];
  logic       out_last_o  [2];
  logic [2:0] sel_o       [2];
  logic       busy_o      [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(0)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_o[0]),
    .out_bit   (out_bit_o[0]),
    .out_valid (out_valid_o[0]),
    .out_ready (out_ready),
    .out_last  (out_last_o[0]),
    .sel       (sel_o[0]),
    .busy      (busy_o[0])
  );

  piso_serializer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready_o[1]),
    .out_bit   (out_bit_o[1]),
    .out_valid (out_valid_o[1]),
    .out_ready (out_ready),
    .out_last  (out_last_o[1]),
    .sel       (sel_o[1]),
    .busy      (busy_o[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  // Model: a word is "bits already sent" out of 8; the index follows from the send order.
  logic [7:0] m_word   [2];
  int         m_sent   [2];
  bit         m_active [2];

  bit cap0[$];
  bit cap1[$];
  int run_len = 0;
  int max_run = 0;

  function automatic int pos_of(input int d, input int n);
    return (d == 1) ? 7 - n : n;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_word[d]   = 8'h00;
      m_sent[d]   = 0;
      m_active[d] = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      int   e_sel;
      logic e_valid, e_last, e_bit, e_inr;
      e_valid = m_active[d];
      e_sel   = e_valid ? pos_of(d, m_sent[d]) : pos_of(d, 0);
      e_last  = e_valid && (m_sent[d] == 7);
      e_bit   = m_word[d][e_sel];
      e_inr   = !rst && (!e_valid || (e_last && out_ready));

      chk("out_valid", d, 32'(out_valid_o[d]), 32'(e_valid));
      chk("busy",      d, 32'(busy_o[d]),      32'(e_valid));
      chk("out_last",  d, 32'(out_last_o[d]),  32'(e_last));
      chk("sel",       d, 32'(sel_o[d]),       32'(e_sel));
      chk("out_bit",   d, 32'(out_bit_o[d]),   32'(e_bit));
      chk("in_ready",  d, 32'(in_ready_o[d]),  32'(e_inr));

      if (!rst && out_valid_o[d] === 1'b1 && out_ready) begin
        if (d == 0) cap0.push_back(out_bit_o[0]);
        else        cap1.push_back(out_bit_o[1]);
      end
      if (d == 0) begin
        if (!rst && out_valid_o[0] === 1'b1 && out_ready) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
      end

      if (rst) begin
        m_word[d]   = 8'h00;
        m_sent[d]   = 0;
        m_active[d] = 1'b0;
      end else if (e_inr && in_valid) begin
        m_word[d]   = in_data;
        m_sent[d]   = 0;
        m_active[d] = 1'b1;
      end else if (e_valid && out_ready) begin
        if (m_sent[d] == 7) begin
          m_active[d] = 1'b0;
          m_sent[d]   = 0;
        end else begin
          m_sent[d] = m_sent[d] + 1;
        end
      end
    end
  end

  task automatic step(input logic r, input logic iv, input logic [7:0] dat, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
  endtask

  // Packs the next n captured bits, first-sent into bit 0.
  task automatic take(input int d, input int n, input string name, input logic [7:0] exp);
    logic [7:0] r;
    int         avail;
    r     = '0;
    avail = (d == 0) ? cap0.size() : cap1.size();
    if (avail < n) begin
      chk({name, "_count"}, d, 32'(avail), 32'(n));
    end else begin
      for (int k = 0; k < n; k++) r[k] = (d == 0) ? cap0.pop_front() : cap1.pop_front();
      chk(name, d, 32'(r), 32'(exp));
    end
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;

    // Reset, then a single A5 word.
    step(1, 0, 8'h00, 1);
    step(1, 1, 8'h77, 1);
    clear_caps();
    step(0, 1, 8'hA5, 1);
    for (int c = 0; c < 9; c++) step(0, 0, 8'h00, 1);
    @(negedge clk);
    take(0, 8, "a5_stream", 8'hA5);
    take(1, 8, "a5_stream", 8'hA5);

    // Backpressure on 3C: stall three cycles at the third bit.
    clear_caps();
    step(0, 1, 8'h3C, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    for (int c = 0; c < 3; c++) step(0, 0, 8'h00, 0);
    for (int c = 0; c < 6; c++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    @(negedge clk);
    take(0, 8, "3c_stream", 8'h3C);
    take(1, 8, "3c_stream", 8'h3C);

    // Back-to-back FF then 00 with no idle gap.
    clear_caps();
    max_run = 0;
    step(0, 1, 8'hFF, 1);
    for (int c = 0; c < 8; c++) step(0, 1, 8'h00, 1);
    for (int c = 0; c < 8; c++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    @(negedge clk);
    chk("b2b_run", 0, 32'(max_run), 32'd16);
    take(0, 8, "ff_stream", 8'hFF);
    take(0, 8, "00_stream", 8'h00);
    take(1, 8, "ff_stream", 8'hFF);
    take(1, 8, "00_stream", 8'h00);

    // 81 presented from the second bit of 5A, held until accepted.
    clear_caps();
    step(0, 1, 8'h5A, 1);
    step(0, 0, 8'h00, 1);
    for (int c = 0; c < 7; c++) step(0, 1, 8'h81, 1);
    for (int c = 0; c < 8; c++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    @(negedge clk);
    take(0, 8, "5a_stream", 8'h5A);
    take(0, 8, "81_stream", 8'h81);
    take(1, 8, "5a_stream", 8'h5A);
    take(1, 8, "81_stream", 8'h81);

    // Reset in the middle of F0: only the first three bits may appear.
    clear_caps();
    step(0, 1, 8'hF0, 1);
    for (int c = 0; c < 3; c++) step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    #3;
    chk("rst_sel",   0, 32'(sel_o[0]),       32'd0);
    chk("rst_sel",   1, 32'(sel_o[1]),       32'd7);
    chk("rst_valid", 0, 32'(out_valid_o[0]), 32'd0);
    chk("rst_busy",  1, 32'(busy_o[1]),      32'd0);
    for (int c = 0; c < 9; c++) step(0, 0, 8'h00, 1);
    @(negedge clk);
    chk("f0_count", 0, 32'(cap0.size()), 32'd3);
    chk("f0_count", 1, 32'(cap1.size()), 32'd3);
    take(0, 3, "f0_head", 8'h00);
    take(1, 3, "f0_head", 8'h07);

    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
